// File: rtl/scroll_background.sv
// Scrolling tile/nametable background renderer: 3-stage registered pipeline
// over synchronous-read nametable and pattern RAMs, 2-bit RGB out.
module scroll_background #(
    parameter int                         VRAM_ADDR_WIDTH = 12,
    parameter logic [VRAM_ADDR_WIDTH-1:0] PMB_BASE        = 12'h200,
    parameter logic [VRAM_ADDR_WIDTH-1:0] NTBL_BASE       = 12'h400,
    parameter int                         PLANE_ROWS      = 30,
    parameter int                         LATENCY         = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 current_x,
    input  logic [7:0]                 current_y,
    input  logic                       pixel_valid_in,
    input  logic                       frame_start,
    input  logic                       writable,
    input  logic [7:0]                 data_in,
    input  logic [VRAM_ADDR_WIDTH-1:0] address,
    input  logic                       write_enable,
    output logic [1:0]                 r,
    output logic [1:0]                 g,
    output logic [1:0]                 b,
    output logic                       pixel_valid_out
);

    localparam logic [8:0] WRAP_H = 9'(PLANE_ROWS * 8);

    // ---------------- write decode ----------------
    logic [VRAM_ADDR_WIDTH-1:0] pmb_off, ntbl_off;
    logic wr_en, pmb_we, ntbl_we, pal_we, sx_we, sy_we, ctrl_we;

    always_comb begin
        wr_en    = write_enable && writable;
        pmb_off  = address - PMB_BASE;
        ntbl_off = address - NTBL_BASE;
        pmb_we   = wr_en && (pmb_off[VRAM_ADDR_WIDTH-1:9] == '0);
        ntbl_we  = wr_en && (ntbl_off[VRAM_ADDR_WIDTH-1:10] == '0);
        pal_we   = ntbl_we && (ntbl_off[9:0] == 10'h3C0);
        sx_we    = ntbl_we && (ntbl_off[9:0] == 10'h3C1);
        sy_we    = ntbl_we && (ntbl_off[9:0] == 10'h3C2);
        ctrl_we  = ntbl_we && (ntbl_off[9:0] == 10'h3C3);
    end

    // ---------------- shadow / active scroll + control ----------------
    logic [7:0] scroll_x_sh_q, scroll_x_sh_d, scroll_y_sh_q, scroll_y_sh_d;
    logic [7:0] scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
    logic       ctrl_en_sh_q, ctrl_en_sh_d, ctrl_en_q, ctrl_en_d;

    always_comb begin
        scroll_x_sh_d = sx_we ? data_in : scroll_x_sh_q;
        scroll_y_sh_d = sy_we ? data_in : scroll_y_sh_q;
        ctrl_en_sh_d  = ctrl_we ? data_in[0] : ctrl_en_sh_q;
        scroll_x_d    = scroll_x_q;
        scroll_y_d    = scroll_y_q;
        ctrl_en_d     = ctrl_en_q;
        // Apply uses the post-write shadow so a same-cycle write lands this frame.
        if (frame_start) begin
            scroll_x_d = scroll_x_sh_d;
            scroll_y_d = ({1'b0, scroll_y_sh_d} >= WRAP_H) ? scroll_y_sh_d - WRAP_H[7:0]
                                                           : scroll_y_sh_d;
            ctrl_en_d  = ctrl_en_sh_d;
        end
    end

    // ---------------- S0: scrolled coordinates, NTBL read ----------------
    logic [7:0] sx, sy;
    logic [8:0] sy_sum;
    logic [9:0] ntbl_raddr;
    logic [2:0] sx_lo_q, sx_lo_d, sy_lo_q, sy_lo_d;

    always_comb begin
        sx         = current_x + scroll_x_q;
        sy_sum     = {1'b0, current_y} + {1'b0, scroll_y_q};
        sy         = (sy_sum >= WRAP_H) ? 8'(sy_sum - WRAP_H) : sy_sum[7:0];
        ntbl_raddr = {sy[7:3], sx[7:3]};
        sx_lo_d    = sx[2:0];
        sy_lo_d    = sy[2:0];
    end

    logic [7:0] ntbl_mem [1024];
    logic [7:0] ntbl_rd_q;

    always_ff @(posedge clk) begin
        if (ntbl_we)
            ntbl_mem[ntbl_off[9:0]] <= data_in;
        ntbl_rd_q <= ntbl_mem[ntbl_raddr];
    end

    // Palette mirrors the NTBL byte so the output stage can read it without a port.
    logic [5:0] palette_q;

    always_ff @(posedge clk) begin
        if (pal_we)
            palette_q <= data_in[5:0];
    end

    // ---------------- S1: entry decode, flips, PMB read ----------------
    logic [2:0] px_q, px_d, py_s1;
    logic       csel_q, csel_d;
    logic [7:0] pmb_raddr;

    always_comb begin
        px_d      = ntbl_rd_q[6] ? ~sx_lo_q : sx_lo_q;
        py_s1     = ntbl_rd_q[5] ? ~sy_lo_q : sy_lo_q;
        csel_d    = ntbl_rd_q[7];
        pmb_raddr = {ntbl_rd_q[4:0], py_s1};
    end

    // Even bytes (high half of a line) and odd bytes live in separate banks.
    logic [7:0] pmb_hi_mem [256];
    logic [7:0] pmb_lo_mem [256];
    logic [7:0] pmb_hi_q, pmb_lo_q;

    always_ff @(posedge clk) begin
        if (pmb_we && !pmb_off[0])
            pmb_hi_mem[pmb_off[8:1]] <= data_in;
        if (pmb_we && pmb_off[0])
            pmb_lo_mem[pmb_off[8:1]] <= data_in;
        pmb_hi_q <= pmb_hi_mem[pmb_raddr];
        pmb_lo_q <= pmb_lo_mem[pmb_raddr];
    end

    // ---------------- S2: pixel select, colour, output ----------------
    logic [15:0]        line;
    logic [1:0]         pix;
    logic [2:0]         colour;
    logic               show;
    logic [1:0]         r_q, r_d, g_q, g_d, b_q, b_d;
    logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;

    always_comb begin
        vld_pipe_d = {vld_pipe_q[LATENCY-2:0], pixel_valid_in};
        line       = {pmb_hi_q, pmb_lo_q};
        pix        = line[{~px_q, 1'b0} +: 2];
        colour     = csel_q ? palette_q[5:3] : palette_q[2:0];
        show       = vld_pipe_q[LATENCY-2] && ctrl_en_q;
        r_d        = show ? (pix & {2{colour[2]}}) : 2'b00;
        g_d        = show ? (pix & {2{colour[1]}}) : 2'b00;
        b_d        = show ? (pix & {2{colour[0]}}) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scroll_x_sh_q <= '0;
            scroll_y_sh_q <= '0;
            scroll_x_q    <= '0;
            scroll_y_q    <= '0;
            ctrl_en_sh_q  <= 1'b0;
            ctrl_en_q     <= 1'b0;
            sx_lo_q       <= '0;
            sy_lo_q       <= '0;
            px_q          <= '0;
            csel_q        <= 1'b0;
            vld_pipe_q    <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            scroll_x_sh_q <= scroll_x_sh_d;
            scroll_y_sh_q <= scroll_y_sh_d;
            scroll_x_q    <= scroll_x_d;
            scroll_y_q    <= scroll_y_d;
            ctrl_en_sh_q  <= ctrl_en_sh_d;
            ctrl_en_q     <= ctrl_en_d;
            sx_lo_q       <= sx_lo_d;
            sy_lo_q       <= sy_lo_d;
            px_q          <= px_d;
            csel_q        <= csel_d;
            vld_pipe_q    <= vld_pipe_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
        end
    end

    assign r               = r_q;
    assign g               = g_q;
    assign b               = b_q;
    assign pixel_valid_out = vld_pipe_q[LATENCY-1];

endmodule

// File: tb/tb_scroll_background.sv
// Scoreboard bench for scroll_background: directed pixels push hand-computed
// colours; negedge monitors pop and compare against both plane-height variants.
module tb_scroll_background;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  cx = '0, cy = '0, data_in = '0;
    logic [11:0] address = '0;
    logic        pv = 1'b0, pv32 = 1'b0, fs = 1'b0, writable = 1'b0, we = 1'b0;
    logic [1:0]  r, g, b, r32, g32, b32;
    logic        pvo, pvo32;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [5:0] rgb;
        int         cyc;
    } exp_t;

    exp_t q30[$];
    exp_t q32[$];
    exp_t e30, e32, tmp;

    logic [1:0] seq_plain [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [1:0] seq_hflip [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};

    scroll_background #(.PLANE_ROWS(30)) dut (
        .clk(clk), .rst(rst), .current_x(cx), .current_y(cy),
        .pixel_valid_in(pv), .frame_start(fs), .writable(writable),
        .data_in(data_in), .address(address), .write_enable(we),
        .r(r), .g(g), .b(b), .pixel_valid_out(pvo)
    );

    scroll_background #(.PLANE_ROWS(32)) dut32 (
        .clk(clk), .rst(rst), .current_x(cx), .current_y(cy),
        .pixel_valid_in(pv32), .frame_start(fs), .writable(writable),
        .data_in(data_in), .address(address), .write_enable(we),
        .r(r32), .g(g32), .b(b32), .pixel_valid_out(pvo32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (pvo) begin
                if (q30.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut30 unexpected pixel: got rgb %0h expected none", {r, g, b});
                end else begin
                    e30 = q30.pop_front();
                    chk("dut30 rgb", {26'd0, r, g, b}, {26'd0, e30.rgb});
                    chk("dut30 latency", cyc - e30.cyc, 3);
                end
            end else begin
                chk("dut30 idle rgb", {26'd0, r, g, b}, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (pvo32) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut32 unexpected pixel: got rgb %0h expected none", {r32, g32, b32});
                end else begin
                    e32 = q32.pop_front();
                    chk("dut32 rgb", {26'd0, r32, g32, b32}, {26'd0, e32.rgb});
                    chk("dut32 latency", cyc - e32.cyc, 3);
                end
            end else begin
                chk("dut32 idle rgb", {26'd0, r32, g32, b32}, 0);
            end
        end
    end

    task automatic step(input logic we_i, input logic wrb_i, input logic [11:0] a,
                        input logic [7:0] d, input logic fs_i, input logic pv_i,
                        input logic pv32_i, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        we = we_i; writable = wrb_i; address = a; data_in = d;
        fs = fs_i; pv = pv_i; pv32 = pv32_i; cx = x; cy = y;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic wr_locked(input logic [11:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, a, d, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic frame();
        step(1'b0, 1'b0, 12'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 12'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic px30(input logic [7:0] x, input logic [7:0] y,
                        input logic [1:0] er, input logic [1:0] eg, input logic [1:0] eb);
        step(1'b0, 1'b0, 12'd0, 8'd0, 1'b0, 1'b1, 1'b0, x, y);
        tmp.rgb = {er, eg, eb};
        tmp.cyc = cyc;
        q30.push_back(tmp);
    endtask

    task automatic grey30(input logic [7:0] x, input logic [7:0] y, input logic [1:0] v);
        px30(x, y, v, v, v);
    endtask

    task automatic grey32(input logic [7:0] x, input logic [7:0] y, input logic [1:0] v);
        step(1'b0, 1'b0, 12'd0, 8'd0, 1'b0, 1'b0, 1'b1, x, y);
        tmp.rgb = {v, v, v};
        tmp.cyc = cyc;
        q32.push_back(tmp);
    endtask

    initial begin
        #12;
        chk("reset r", {30'd0, r}, 0);
        chk("reset g", {30'd0, g}, 0);
        chk("reset b", {30'd0, b}, 0);
        chk("reset pvo", {31'd0, pvo}, 0);
        chk("reset dut32 rgb", {26'd0, r32, g32, b32}, 0);
        chk("reset dut32 pvo", {31'd0, pvo32}, 0);
        @(negedge clk);
        rst = 1'b1;

        // pattern 1: line0 1B E4, line7 FF FF; pattern 2 line0 1B 00
        wr(12'h210, 8'h1B); wr(12'h211, 8'hE4);
        wr(12'h21E, 8'hFF); wr(12'h21F, 8'hFF);
        wr(12'h220, 8'h1B); wr(12'h221, 8'h00);
        // pattern 3: line4 00 40, line5 40 80; pattern 4 line7 C0 00
        wr(12'h238, 8'h00); wr(12'h239, 8'h40);
        wr(12'h23A, 8'h40); wr(12'h23B, 8'h80);
        wr(12'h24E, 8'hC0); wr(12'h24F, 8'h00);
        wr(12'h400, 8'h01); wr(12'h401, 8'h42); wr(12'h402, 8'h82);
        wr(12'h420, 8'h21); wr(12'h41F, 8'h03); wr(12'h7E0, 8'h04);
        wr(12'h7C0, 8'h0F);

        // still disabled after reset
        grey30(8'd3, 8'd0, 2'd0);
        idle(4);

        wr(12'h7C3, 8'h01);
        frame();
        for (int i = 0; i < 8; i++) grey30(8'(i), 8'd0, seq_plain[i]);
        for (int i = 0; i < 8; i++) grey30(8'(i + 8), 8'd0, seq_hflip[i]);
        for (int i = 0; i < 4; i++) px30(8'(i + 16), 8'd0, 2'd0, 2'd0, 2'(i));
        for (int i = 0; i < 4; i++) grey30(8'(i), 8'd15, 2'(i));
        grey30(8'd0, 8'd8, 2'd3);
        idle(4);

        // shadow writes must not take effect before frame_start
        wr(12'h7C1, 8'hFC);
        wr(12'h7C2, 8'hF5);
        grey30(8'd1, 8'd0, 2'd1);
        frame();
        grey30(8'd0, 8'd0, 2'd2);
        grey30(8'd0, 8'd239, 2'd1);
        idle(4);

        // locked writes leave shadow and RAM alone
        wr_locked(12'h7C1, 8'h00);
        wr_locked(12'h23B, 8'hFF);
        frame();
        grey30(8'd0, 8'd0, 2'd2);
        idle(4);

        // write coinciding with frame_start applies immediately
        step(1'b1, 1'b1, 12'h7C1, 8'hF8, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        grey30(8'd0, 8'd0, 2'd1);
        idle(4);

        // 32-row plane: scroll_y 0xFF wraps mod 256
        wr(12'h7C1, 8'h00);
        wr(12'h7C2, 8'hFF);
        frame();
        grey32(8'd0, 8'd0, 2'd3);
        grey32(8'd1, 8'd1, 2'd1);
        idle(4);

        wr(12'h7C3, 8'h00);
        frame();
        grey30(8'd1, 8'd0, 2'd0);
        idle(4);

        // reset mid-line drops outputs asynchronously and flushes the pipe
        wr(12'h7C3, 8'h01);
        frame();
        grey30(8'd1, 8'd0, 2'd1);
        grey30(8'd2, 8'd0, 2'd2);
        grey30(8'd3, 8'd0, 2'd3);
        grey30(8'd1, 8'd0, 2'd1);
        idle(1);
        #2;
        chk("pvo before rst", {31'd0, pvo}, 1);
        rst = 1'b0;
        q30.delete();
        #1;
        chk("async rst rgb", {26'd0, r, g, b}, 0);
        chk("async rst pvo", {31'd0, pvo}, 0);
        idle(2);
        #2;
        rst = 1'b1;

        grey30(8'd1, 8'd0, 2'd0);
        idle(4);
        wr(12'h7C3, 8'h01);
        frame();
        grey30(8'd0, 8'd7, 2'd3);
        idle(6);

        chk("dut30 queue drained", q30.size(), 0);
        chk("dut32 queue drained", q32.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
